// File: rtl/alu_issue.sv
// alu_issue: decode-to-EX issue register with load-use/RAW hazard stall; optional forwarding via ALU_ISSUE_FWD_EN.
// Latency: one cycle from the decode handshake to ex_valid; forwarded operands are combinational from MEM/WB.
// Backpressure: id_ready drops on a hazard or while EX is held by !ex_ready; EX contents hold until ex_ready.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs1_val,
    input  logic [31:0] id_rs2_val,
    input  logic [31:0] id_imm,
    input  logic        id_use_imm,
    input  logic [3:0]  id_alu_op,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [31:0] ex_in1,
    output logic [31:0] ex_in2,
    output logic [3:0]  ex_op,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [31:0] mem_result,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    input  logic [31:0] wb_result,
    output logic [15:0] stall_cnt
);

    logic        r_ex_valid;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [31:0] r_rs1_val;
    logic [31:0] r_rs2_val;
    logic [31:0] r_imm;
    logic        r_use_imm;
    logic [3:0]  r_op;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_mem_read;
    logic [15:0] r_stall_cnt;

    logic        w_load_use;
    logic        w_hazard;
    logic        w_capture;

    // A writer targets a register only if it writes and the destination is not x0.
    function automatic logic f_match(input logic we, input logic [4:0] rd, input logic [4:0] tag);
        return we && (rd != 5'd0) && (rd == tag);
    endfunction

    // True when register r is a source actually read by the decode instruction.
    function automatic logic f_used(input logic [4:0] r);
        return (r != 5'd0) && ((r == id_rs1) || (!id_use_imm && (r == id_rs2)));
    endfunction

    assign w_load_use = r_ex_valid && r_mem_read && f_used(r_rd);

`ifdef ALU_ISSUE_FWD_EN
    // MEM is younger than WB, so it wins when both write the same register.
    function automatic logic [31:0] f_fwd(input logic [4:0] tag, input logic [31:0] regval);
        if (f_match(mem_reg_write, mem_rd, tag)) return mem_result;
        if (f_match(wb_reg_write, wb_rd, tag))   return wb_result;
        return regval;
    endfunction

    assign w_hazard = w_load_use;
    assign ex_in1   = f_fwd(r_rs1, r_rs1_val);
    assign ex_in2   = r_use_imm ? r_imm : f_fwd(r_rs2, r_rs2_val);
`else
    logic w_unused_ok;

    // Without forwarding, any in-flight writer of a used source must drain first.
    assign w_hazard = w_load_use
                   || (r_ex_valid && r_reg_write && f_used(r_rd))
                   || (mem_reg_write && f_used(mem_rd))
                   || (wb_reg_write && f_used(wb_rd));
    assign ex_in1   = r_rs1_val;
    assign ex_in2   = r_use_imm ? r_imm : r_rs2_val;
    assign w_unused_ok = ^{mem_result, wb_result, r_rs1, r_rs2};
`endif

    assign id_ready     = !rst && !w_hazard && (!r_ex_valid || ex_ready);
    assign w_capture    = id_valid && id_ready;
    assign ex_valid     = r_ex_valid;
    assign ex_op        = r_op;
    assign ex_rd        = r_rd;
    assign ex_reg_write = r_reg_write;
    assign ex_mem_read  = r_mem_read;
    assign stall_cnt    = r_stall_cnt;

    // EX register: reset > flush > capture > drain; otherwise hold for backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rs1_val   <= 32'd0;
            r_rs2_val   <= 32'd0;
            r_imm       <= 32'd0;
            r_use_imm   <= 1'b0;
            r_op        <= 4'd0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (flush) begin
            r_ex_valid  <= 1'b0;
        end else if (w_capture) begin
            r_ex_valid  <= 1'b1;
            r_rs1       <= id_rs1;
            r_rs2       <= id_rs2;
            r_rs1_val   <= id_rs1_val;
            r_rs2_val   <= id_rs2_val;
            r_imm       <= id_imm;
            r_use_imm   <= id_use_imm;
            r_op        <= id_alu_op;
            r_rd        <= id_rd;
            r_reg_write <= id_reg_write && (id_rd != 5'd0);
            r_mem_read  <= id_mem_read;
        end else if (ex_ready) begin
            r_ex_valid  <= 1'b0;
        end
    end

    // Saturating count of cycles where decode was blocked by a hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (id_valid && w_hazard && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_val, id_rs2_val, id_imm;
    logic        id_use_imm;
    logic [3:0]  id_alu_op;
    logic        id_reg_write, id_mem_read;
    logic        flush, ex_ready;
    logic        ex_valid;
    logic [31:0] ex_in1, ex_in2;
    logic [3:0]  ex_op;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic [15:0] stall_cnt;

    alu_issue dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_op(ex_op), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: the single instruction occupying EX plus the stall counter.
    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2, imm;
        logic        use_imm;
        logic [3:0]  op;
        logic        we, mr;
    } ins_t;

    bit   m_valid = 1'b0;
    ins_t m_ins   = '0;
    int   m_stall = 0;

    function automatic logic uses(input logic [4:0] r);
        return (r != 5'd0) && ((r == id_rs1) || (!id_use_imm && (r == id_rs2)));
    endfunction

    function automatic logic [31:0] pick(input logic [4:0] tag, input logic [31:0] regval);
`ifdef ALU_ISSUE_FWD_EN
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == tag) return mem_result;
        if (wb_reg_write && wb_rd != 5'd0 && wb_rd == tag) return wb_result;
`endif
        return regval;
    endfunction

    // Compare process: checks every output each cycle, then advances the model for the coming edge.
    always @(negedge clk) begin : compare
        logic hz, rdy;
        ins_t cur;
        if (chk_en) begin
            hz = m_valid && m_ins.mr && uses(m_ins.rd);
`ifndef ALU_ISSUE_FWD_EN
            hz = hz || (m_valid && m_ins.we && uses(m_ins.rd))
                    || (mem_reg_write && uses(mem_rd))
                    || (wb_reg_write && uses(wb_rd));
`endif
            rdy = !rst && !hz && (!m_valid || ex_ready);
            chk("id_ready", {31'd0, id_ready}, {31'd0, rdy});
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
            chk("ex_in1", ex_in1, pick(m_ins.rs1, m_ins.v1));
            chk("ex_in2", ex_in2, m_ins.use_imm ? m_ins.imm : pick(m_ins.rs2, m_ins.v2));
            chk("ex_op", {28'd0, ex_op}, {28'd0, m_ins.op});
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_ins.rd});
            chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_ins.we && (m_ins.rd != 5'd0)});
            chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_ins.mr});
            chk("stall_cnt", {16'd0, stall_cnt}, m_stall);

            cur = '{id_rs1, id_rs2, id_rd, id_rs1_val, id_rs2_val, id_imm,
                    id_use_imm, id_alu_op, id_reg_write, id_mem_read};
            if (rst) begin
                m_valid = 1'b0;
                m_ins   = '0;
                m_stall = 0;
            end else begin
                if (id_valid && hz && m_stall < 65535) m_stall++;
                if (flush) m_valid = 1'b0;
                else if (id_valid && rdy) begin
                    m_valid = 1'b1;
                    m_ins   = cur;
                end else if (ex_ready) m_valid = 1'b0;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; id_valid = 0; flush = 0; ex_ready = 1;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_val = 0; id_rs2_val = 0; id_imm = 0;
        id_use_imm = 0; id_alu_op = 0; id_reg_write = 0; id_mem_read = 0;
        mem_rd = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_result = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                          input logic use_imm, input logic [3:0] op, input logic we, input logic mr);
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_val = v1; id_rs2_val = v2; id_imm = imm;
        id_use_imm = use_imm; id_alu_op = op; id_reg_write = we; id_mem_read = mr;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; id_valid = 1;
        repeat (2) begin
            cycle();
            chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
            chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
            chk("rst_id_ready", {31'd0, id_ready}, 32'd0);
        end
        rst = 0;
        #1;
        chk("post_rst_id_ready", {31'd0, id_ready}, 32'd1);
        id_valid = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        cycle();
        chk_en = 1'b1;

        // Reset behaviour with decode asserting valid.
        do_reset();
        chk("rst_ex_in1", ex_in1, 32'd0);
        chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);

        // Load-use: lw x5 in EX, add reading x5 stalls one cycle then issues.
        set_id(5'd1, 5'd2, 5'd5, 32'h100, 32'h200, 32'd0, 1'b0, 4'd0, 1'b1, 1'b1);
        id_valid = 1;
        cycle();
        chk("lu_ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
        set_id(5'd5, 5'd6, 5'd7, 32'hCAFE0001, 32'h66, 32'd0, 1'b0, 4'd2, 1'b1, 1'b0);
        #1;
        chk("lu_id_ready", {31'd0, id_ready}, 32'd0);
        cycle();
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_stall", {16'd0, stall_cnt}, 32'd1);
        chk("lu_ready_again", {31'd0, id_ready}, 32'd1);
        cycle();
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_rd", {27'd0, ex_rd}, 32'd7);
        chk("lu_add_in1", ex_in1, 32'hCAFE0001);
        id_valid = 0;
        cycle();

        // Backpressure: EX held three cycles while a new instruction waits.
        do_reset();
        set_id(5'd1, 5'd2, 5'd9, 32'h12345678, 32'h9, 32'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        id_valid = 1;
        cycle();
        ex_ready = 0;
        set_id(5'd10, 5'd11, 5'd12, 32'hDEAD, 32'hBEEF, 32'd0, 1'b0, 4'd4, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_id_ready", {31'd0, id_ready}, 32'd0);
            cycle();
            chk("bp_ex_rd", {27'd0, ex_rd}, 32'd9);
            chk("bp_ex_in1", ex_in1, 32'h12345678);
            chk("bp_ex_op", {28'd0, ex_op}, 32'd3);
            chk("bp_stall", {16'd0, stall_cnt}, 32'd0);
        end
        ex_ready = 1;
        id_valid = 0;
        cycle();

        // Flush on the same edge as a valid decode drops both.
        do_reset();
        set_id(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        id_valid = 1;
        cycle();
        set_id(5'd4, 5'd5, 5'd6, 32'h4, 32'h5, 32'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        flush = 1;
        cycle();
        chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        flush = 0; id_valid = 0;
        cycle();
        chk("flush_dropped", {31'd0, ex_valid}, 32'd0);

        // Operand source selection with MEM and WB both targeting x3.
        do_reset();
        set_id(5'd3, 5'd4, 5'd8, 32'h11111111, 32'h22, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        id_valid = 1;
        cycle();
        id_valid = 0; ex_ready = 0;
        mem_rd = 5'd3; mem_reg_write = 1; mem_result = 32'hAAAA0000;
        wb_rd = 5'd3; wb_reg_write = 1; wb_result = 32'h5555;
        #1;
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_mem", ex_in1, 32'hAAAA0000);
`else
        chk("nofwd_mem", ex_in1, 32'h11111111);
`endif
        mem_rd = 5'd0;
        #1;
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_wb", ex_in1, 32'h5555);
`else
        chk("nofwd_wb", ex_in1, 32'h11111111);
`endif
        cycle();
        idle();
        cycle();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rst        = ($urandom_range(0, 63) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            ex_ready   = ($urandom_range(0, 3) != 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0));
            mem_rd        = 5'($urandom_range(0, 7));
            mem_reg_write = ($urandom_range(0, 3) == 0);
            mem_result    = $urandom;
            wb_rd         = 5'($urandom_range(0, 7));
            wb_reg_write  = ($urandom_range(0, 3) == 0);
            wb_result     = $urandom;
            cycle();
        end

        // Saturation: a load-use hazard held against a stalled EX.
        do_reset();
        set_id(5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b1);
        id_valid = 1;
        cycle();
        ex_ready = 0;
        set_id(5'd5, 5'd6, 5'd7, 32'h0, 32'h0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        repeat (65540) cycle();
        chk("sat_stall", {16'd0, stall_cnt}, 32'h0000FFFF);
        chk("sat_ex_valid", {31'd0, ex_valid}, 32'd1);

        idle();
        cycle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
